// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the forwarding/hazard controller.
// Holds forwarding select codes, register index width and the dest-entry record.
package pipe_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } dest_entry_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side request and EX-side select bundle for fwd_hazard_ctrl.
// master: ID stage drives id_*/flush; slave: controller drives selects, stall, stall_cnt.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_regwrite, id_memread, flush,
        input  ForwardA, ForwardB, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_regwrite, id_memread, flush,
        output ForwardA, ForwardB, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Forward-select for one source operand; newest producer (EX) beats MEM.
// Ports: rs/use_rs, ex/mem entries in; sel (2-bit code) and hit_ex out. ZERO_REG_EN: r0 never hits.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  dest_entry_t       ex,
    input  dest_entry_t       mem,
    output logic [1:0]        sel,
    output logic              hit_ex
);

    logic rs_ok;
    logic hit_mem;
    logic unused_ld;

`ifdef ZERO_REG_EN
    assign rs_ok = use_rs & (rs != '0);
`else
    assign rs_ok = use_rs;
`endif

    assign hit_ex  = rs_ok & ex.valid & ex.regwrite & (ex.rd == rs);
    assign hit_mem = rs_ok & mem.valid & mem.regwrite & (mem.rd == rs);

    // load flags only matter to the stall logic upstream
    assign unused_ld = ex.memread ^ mem.memread;

    // both hits may be true at once, so this is a priority chain
    always_comb begin
        sel = FWD_IDEX;
        if (hit_ex)
            sel = FWD_EXMEM;
        else if (hit_mem)
            sel = FWD_MEMWB;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM producers, registers selects.
// Ports: clk, rst_n (async low), bus (slave: id_*, flush in; ForwardA/B, stall, stall_cnt out).
// Build option ZERO_REG_EN: register 0 is hardwired zero (never forwarded, never stalls).
module fwd_hazard_ctrl
    import pipe_pkg::dest_entry_t;
    import pipe_pkg::FWD_IDEX;
#(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_ctrl_if.slave   bus
);

    dest_entry_t       ex_q;
    dest_entry_t       mem_q;
    dest_entry_t       id_ent;
    logic [1:0]        fa_q;
    logic [1:0]        fb_q;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              hit_ex_a;
    logic              hit_ex_b;
    logic              stall;
    logic              wr_eff;
    logic [REG_AW-1:0] id_rd;
    logic [CNT_W-1:0]  cnt_q;

    assign id_rd = bus.id_rd;

`ifdef ZERO_REG_EN
    assign wr_eff = bus.id_regwrite & (id_rd != '0);
`else
    assign wr_eff = bus.id_regwrite;
`endif

    assign id_ent = '{
        valid:    bus.id_valid,
        rd:       id_rd,
        regwrite: wr_eff,
        memread:  bus.id_memread
    };

    fwd_sel u_sel_a (
        .rs     (bus.id_rs1),
        .use_rs (bus.id_use_rs1),
        .ex     (ex_q),
        .mem    (mem_q),
        .sel    (sel_a),
        .hit_ex (hit_ex_a)
    );

    fwd_sel u_sel_b (
        .rs     (bus.id_rs2),
        .use_rs (bus.id_use_rs2),
        .ex     (ex_q),
        .mem    (mem_q),
        .sel    (sel_b),
        .hit_ex (hit_ex_b)
    );

    // load in EX feeding ID: data only exists after MEM, so hold one cycle
    assign stall = bus.id_valid & ~bus.flush & ex_q.valid & ex_q.memread
                 & (hit_ex_a | hit_ex_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            fa_q  <= FWD_IDEX;
            fb_q  <= FWD_IDEX;
        end else begin
            mem_q <= ex_q;
            if (bus.flush || stall) begin
                ex_q <= '0;
                fa_q <= FWD_IDEX;
                fb_q <= FWD_IDEX;
            end else begin
                ex_q <= id_ent;
                fa_q <= bus.id_valid ? sel_a : FWD_IDEX;
                fb_q <= bus.id_valid ? sel_b : FWD_IDEX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.ForwardA  = fa_q;
    assign bus.ForwardB  = fb_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed program then random instructions.
// Reference model walks an instruction history and looks up the youngest producer.
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int NCYC  = 500;

    typedef struct {
        bit       v;
        bit [3:0] rs1;
        bit       u1;
        bit [3:0] rs2;
        bit       u2;
        bit [3:0] rd;
        bit       wr;
        bit       ld;
        bit       fl;
    } instr_t;

    typedef struct {
        bit       v;
        bit [3:0] rd;
        bit       wr;
        bit       ld;
    } prod_t;

    typedef struct {
        bit [1:0] fa;
        bit [1:0] fb;
        int       cnt;
    } post_t;

    logic clk;
    logic rst_n;

    fwd_hazard_ctrl_if #(.REG_AW(4), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_AW(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total;
    int    passed;
    bit    stall_q[$];
    post_t post_q[$];
    prod_t hist[$];
    int    cnt_m;
    bit    mon_on;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // stage 0 = EX, stage 1 = MEM; the youngest matching writer wins
    function automatic bit [1:0] fwd_code(input bit [3:0] rs, input bit u);
`ifdef ZERO_REG_EN
        if (rs == 0)
            return 2'b00;
`endif
        if (!u)
            return 2'b00;
        for (int s = 0; s < 2; s++)
            if (hist[s].v && hist[s].wr && hist[s].rd == rs)
                return (s == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic instr_t mk(input bit v, input int rs1, input bit u1,
                                  input int rs2, input bit u2, input int rd,
                                  input bit wr, input bit ld, input bit fl);
        instr_t i;
        i.v = v; i.rs1 = 4'(rs1); i.u1 = u1; i.rs2 = 4'(rs2); i.u2 = u2;
        i.rd = 4'(rd); i.wr = wr; i.ld = ld; i.fl = fl;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        i.v   = ($urandom % 8) != 0;
        i.rs1 = 4'($urandom % 4);
        i.u1  = 1'($urandom);
        i.rs2 = 4'($urandom % 4);
        i.u2  = 1'($urandom);
        i.rd  = 4'($urandom % 4);
        i.wr  = ($urandom % 4) != 0;
        i.ld  = ($urandom % 3) == 0;
        i.fl  = ($urandom % 8) == 0;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        bus.id_valid    = i.v;
        bus.id_rs1      = i.rs1;
        bus.id_use_rs1  = i.u1;
        bus.id_rs2      = i.rs2;
        bus.id_use_rs2  = i.u2;
        bus.id_rd       = i.rd;
        bus.id_regwrite = i.wr;
        bus.id_memread  = i.ld;
        bus.flush       = i.fl;
    endtask

    // one cycle of the reference: predicts stall now and selects after the edge
    task automatic model_step(input instr_t i, output bit st);
        bit [1:0] ca, cb;
        prod_t    nx;
        post_t    p;
        ca = fwd_code(i.rs1, i.u1);
        cb = fwd_code(i.rs2, i.u2);
        st = i.v && !i.fl && hist[0].v && hist[0].ld
             && (ca == 2'b10 || cb == 2'b10);
        if (i.fl || st) begin
            nx = '{v: 1'b0, rd: 4'd0, wr: 1'b0, ld: 1'b0};
            p.fa = 2'b00;
            p.fb = 2'b00;
        end else begin
            nx.v  = i.v;
            nx.rd = i.rd;
            nx.wr = i.wr;
`ifdef ZERO_REG_EN
            if (i.rd == 0)
                nx.wr = 1'b0;
`endif
            nx.ld = i.ld;
            p.fa = i.v ? ca : 2'b00;
            p.fb = i.v ? cb : 2'b00;
        end
        if (st && cnt_m < CMAX)
            cnt_m++;
        p.cnt = cnt_m;
        hist.push_front(nx);
        void'(hist.pop_back());
        stall_q.push_back(st);
        post_q.push_back(p);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_on && stall_q.size() > 0)
            check("stall", int'(bus.stall), int'(stall_q.pop_front()));
    end

    always @(posedge clk) begin
        post_t e;
        #1;
        if (mon_on && post_q.size() > 0) begin
            e = post_q.pop_front();
            check("ForwardA", int'(bus.ForwardA), int'(e.fa));
            check("ForwardB", int'(bus.ForwardB), int'(e.fb));
            check("stall_cnt", int'(bus.stall_cnt), e.cnt);
        end
    end

    instr_t dir[$];
    instr_t cur;
    bit     held;
    bit     st;
    int     k;

    initial begin
        total  = 0;
        passed = 0;
        cnt_m  = 0;
        mon_on = 1'b1;
        held   = 1'b0;
        k      = 0;
        hist.push_back('{v: 1'b0, rd: 4'd0, wr: 1'b0, ld: 1'b0});
        hist.push_back('{v: 1'b0, rd: 4'd0, wr: 1'b0, ld: 1'b0});

        // ADD r3; ADD r4,r3,r5; ADD r3; NOP; SUB r6,r1,r3
        dir.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0));
        dir.push_back(mk(1, 3, 1, 5, 1, 4, 1, 0, 0));
        dir.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0));
        dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        dir.push_back(mk(1, 1, 1, 3, 1, 6, 1, 0, 0));
        // LW r2; ADD r7,r2,r2 (one stall then 01/01)
        dir.push_back(mk(1, 1, 1, 0, 0, 2, 1, 1, 0));
        dir.push_back(mk(1, 2, 1, 2, 1, 7, 1, 0, 0));
        // ADD r3; ADD r3; OR r8,r3,r1
        dir.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0));
        dir.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0));
        dir.push_back(mk(1, 3, 1, 1, 1, 8, 1, 0, 0));
        // LW r2; dependent ADD killed by flush
        dir.push_back(mk(1, 1, 1, 0, 0, 2, 1, 1, 0));
        dir.push_back(mk(1, 2, 1, 2, 1, 7, 1, 0, 1));
        // r0 producer then consumer, and load to r0
        dir.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0));
        dir.push_back(mk(1, 0, 1, 0, 1, 9, 1, 0, 0));
        dir.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0));
        dir.push_back(mk(1, 0, 1, 0, 1, 9, 1, 0, 0));

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("rst ForwardA", int'(bus.ForwardA), 0);
        check("rst ForwardB", int'(bus.ForwardB), 0);
        check("rst stall_cnt", int'(bus.stall_cnt), 0);
        check("rst stall", int'(bus.stall), 0);
        rst_n = 1'b1;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (held) begin
                cur.fl = 1'b0;
            end else begin
                cur = (k < dir.size()) ? dir[k] : rnd();
                k++;
            end
            drive(cur);
            model_step(cur, st);
            held = st;
        end

        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #2;
        if (stall_q.size() != 0 || post_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0",
                     stall_q.size(), post_q.size());
        end
        mon_on = 1'b0;

        // reset in the middle of a load-use stall
        @(negedge clk);
        drive(mk(1, 1, 1, 0, 0, 2, 1, 1, 0));
        @(negedge clk);
        drive(mk(1, 2, 1, 2, 1, 7, 1, 0, 0));
        #1;
        check("pre-reset stall", int'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        check("async rst stall", int'(bus.stall), 0);
        check("async rst ForwardA", int'(bus.ForwardA), 0);
        check("async rst ForwardB", int'(bus.ForwardB), 0);
        check("async rst stall_cnt", int'(bus.stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and load-use hazard controller for the 16-bit 5-stage pipeline. It is the producer of the ForwardA/ForwardB select codes consumed by the operand-A and operand-B forwarding muxes in EX. It tracks destination-register info for the in-flight instructions in ID/EX and EX/MEM, registers the select codes as each instruction enters EX, and raises a one-cycle stall on load-use.

Parameters:
REG_AW, 4, register index width (16 architectural registers)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source register 1 (operand A)
id_rs2  in  REG_AW  ID source register 2 (operand B)
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination register
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
flush  in  1  branch or jump taken; kill the ID instruction this cycle
ForwardA  out  2  EX operand-A select, registered
ForwardB  out  2  EX operand-B select, registered
stall  out  1  hold PC and IF/ID this cycle (combinational from flops and ID inputs)
stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:
- Select encoding:
  - 00: IDEX register-file value.
  - 10: EXMEM prior ALU result.
  - 01: MEMWB data-memory or earlier ALU result.
  - 11 is never driven.
- Internal tracking entries, each holding {valid, rd, regwrite, memread}:
  - ex_*: the instruction currently in EX.
  - mem_*: the instruction currently in MEM.
- Hit definitions for a source rsX:
  - hitEX(rsX) = id_use_rsX & ex_valid & ex_regwrite & (ex_rd == rsX)
  - hitMEM(rsX) = id_use_rsX & mem_valid & mem_regwrite & (mem_rd == rsX)
- stall = id_valid & ~flush & ex_valid & ex_memread & (hitEX(rs1) | hitEX(rs2)).
- Each rising edge, in priority order:
  1. flush=1: ex_* ← bubble (valid=0); ForwardA/B ← 00; mem_* ← ex_*.
  2. stall=1: ex_* ← bubble; ForwardA/B ← 00; mem_* ← ex_*. The ID instruction is held upstream and re-evaluated next cycle.
  3. Otherwise:
     - ex_* ← {id_valid, id_rd, id_regwrite, id_memread}; mem_* ← ex_*.
     - ForwardA ← hitEX(rs1) ? 10 : hitMEM(rs1) ? 01 : 00. ForwardB likewise for rs2.
     - Newest producer wins: EXMEM has priority over MEMWB.
     - id_valid=0 → ForwardA/B ← 00.
- Latency: the select codes are valid in the same cycle the consuming instruction sits in EX, i.e. one edge after its ID evaluation.
- Load-use example:
  - Load in EX, dependent instruction in ID → exactly one stall cycle.
  - Next cycle the load is in MEM, so hitMEM applies and the dependent instruction gets 01 in EX.
  - No second stall.
- A writeback-stage producer is not forwarded. The register file provides write-before-read in the same cycle.
- rs1 == rs2 with both used and both hitting → ForwardA and ForwardB carry identical codes.
- stall_cnt: +1 on every edge with stall=1; holds at all-ones.
- Reset (async, rst_n=0):
  - ex_valid=0, mem_valid=0, ForwardA=00, ForwardB=00, stall_cnt=0.
  - stall reads 0 because ex_valid=0.
- Reset mid-stall: the stall drops immediately and asynchronously; the in-flight load is discarded.

Optional Feature:
ZERO_REG_EN:
- Defined: register index 0 is hardwired zero. Any rsX == 0 never produces a hit, so it never forwards and never stalls. Entries with rd == 0 are captured with regwrite forced to 0.
- Undefined: register 0 is treated like any other register.

Decomposition:
- Shared package pipe_pkg holds:
  - constants FWD_IDEX=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, REG_AW;
  - typedef dest_entry_t {valid, rd, regwrite, memread}.
- One sub-module, fwd_sel (combinational): given rsX, use, ex entry and mem entry, returns a 2-bit select and hitEX. Instantiated twice, for A and B.
- Stall logic and tracking flops stay in the top level.

Test Plan:
- ADD r3 then ADD r4,r3,r5 back-to-back → second instruction in EX sees ForwardA=10, ForwardB=00; stall never asserted.
- ADD r3; NOP; SUB r6,r1,r3 → SUB in EX sees ForwardB=01, ForwardA=00.
- LW r2 then ADD r7,r2,r2 → stall=1 for exactly 1 cycle; then ForwardA=ForwardB=01 in EX; stall_cnt increments 0→1.
- ADD r3 then ADD r3 then OR r8,r3,r1 → OR gets ForwardA=10 (newest producer wins over 01).
- LW r2 in EX with dependent instruction in ID and flush=1 → stall=0; ForwardA/B=00 next cycle; stall_cnt unchanged. Separately, force stall_cnt to 0xFFFF, then stall again → holds at 0xFFFF.
- With ZERO_REG_EN: ADD r0 then use r0 → ForwardA=00. LW r0 then use r0 → no stall. Assert rst_n low during a stall cycle → stall=0, Forward=00, stall_cnt=0 immediately.
